decode_stage: RTL and testbench

- Registered, handshaked RV32I instruction-decode pipeline stage.
- Sits between fetch and register-file/execute. Takes one instruction word plus its PC and produces opcode key, register indices, an XLEN-wide immediate and an illegal-instruction flag one cycle later.
- Extends the combinational decoder with sign-extension, illegal-instruction detection, a valid/ready pipeline register, flush and a decode counter.

---
 rtl/decode_stage.sv | 163 ++++++++++++++++
 tb/tb_decode_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: combinational field/immediate decode feeding a
// single valid/ready output register with flush and a completed-output counter.
module decode_stage #(
   parameter int XLEN         = 32,
   parameter bit SIGN_EXT_IMM = 1'b1,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      INST,
   input  logic [XLEN-1:0]  pc_in,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      opcode,
   output logic [4:0]       rd,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [XLEN-1:0]  imm,
   output logic [XLEN-1:0]  pc_out,
   output logic             illegal,
   output logic [CNT_W-1:0] decode_count
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   logic [6:0]      op;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] ext;
   logic [15:0]     d_opcode;
   logic [4:0]      d_rd, d_rs1, d_rs2;
   logic [XLEN-1:0] d_imm;
   logic            d_illegal;
   logic            capture;

   assign op = INST[6:0];
   assign f3 = INST[14:12];
   assign f7 = INST[31:25];

   // Every RV32I immediate has its sign at INST[31]; the low bits are overlaid on ext.
   assign ext = SIGN_EXT_IMM ? {XLEN{INST[31]}} : '0;

   // NOTE: every output of this block gets a default first so no path leaves a latch.
   always_comb begin
      d_opcode  = '0;
      d_rd      = '0;
      d_rs1     = '0;
      d_rs2     = '0;
      d_imm     = '0;
      d_illegal = 1'b0;
      case (op)
         OP_R: begin
            d_opcode  = {f7[5:0], f3, op};
            d_rd      = INST[11:7];
            d_rs1     = INST[19:15];
            d_rs2     = INST[24:20];
            d_illegal = !(f7 == 7'b0000000 || f7 == 7'b0100000) ||
                        (f7 == 7'b0100000 && !(f3 == 3'b000 || f3 == 3'b101));
         end
         OP_IMM: begin
            d_opcode    = {(f3 == 3'b001 || f3 == 3'b101) ? f7[5:0] : 6'b0, f3, op};
            d_rd        = INST[11:7];
            d_rs1       = INST[19:15];
            d_imm       = ext;
            d_imm[11:0] = INST[31:20];
            d_illegal   = (f3 == 3'b001 && f7 != 7'b0000000) ||
                          (f3 == 3'b101 && !(f7 == 7'b0000000 || f7 == 7'b0100000));
         end
         OP_LOAD: begin
            d_opcode    = {6'b0, f3, op};
            d_rd        = INST[11:7];
            d_rs1       = INST[19:15];
            d_imm       = ext;
            d_imm[11:0] = INST[31:20];
            d_illegal   = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
         end
         OP_STORE: begin
            d_opcode    = {6'b0, f3, op};
            d_rs1       = INST[19:15];
            d_rs2       = INST[24:20];
            d_imm       = ext;
            d_imm[11:0] = {INST[31:25], INST[11:7]};
            d_illegal   = (f3 >= 3'b011);
         end
         OP_BRANCH: begin
            d_opcode    = {6'b0, f3, op};
            d_rs1       = INST[19:15];
            d_rs2       = INST[24:20];
            d_imm       = ext;
            d_imm[12:0] = {INST[31], INST[7], INST[30:25], INST[11:8], 1'b0};
            d_illegal   = (f3 == 3'b010 || f3 == 3'b011);
         end
         OP_LUI, OP_AUIPC: begin
            d_opcode    = {9'b0, op};
            d_rd        = INST[11:7];
            d_imm       = ext;
            d_imm[31:0] = {INST[31:12], 12'b0};
         end
         OP_JAL: begin
            d_opcode    = {9'b0, op};
            d_rd        = INST[11:7];
            d_imm       = ext;
            d_imm[20:0] = {INST[31], INST[19:12], INST[20], INST[30:21], 1'b0};
         end
         OP_JALR: begin
            d_opcode    = {9'b0, op};
            d_rd        = INST[11:7];
            d_rs1       = INST[19:15];
            d_imm       = ext;
            d_imm[11:0] = INST[31:20];
            d_illegal   = (f3 != 3'b000);
         end
         default: d_illegal = 1'b1;
      endcase
   end

   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   // NOTE: state registers use non-blocking assignments so all of them update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         opcode       <= '0;
         rd           <= '0;
         rs1          <= '0;
         rs2          <= '0;
         imm          <= '0;
         pc_out       <= '0;
         illegal      <= 1'b0;
         decode_count <= '0;
      end else begin
         if (flush)          out_valid <= 1'b0;
         else if (capture)   out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;

         if (capture) begin
            opcode  <= d_opcode;
            rd      <= d_rd;
            rs1     <= d_rs1;
            rs2     <= d_rs2;
            imm     <= d_imm;
            pc_out  <= pc_in;
            illegal <= d_illegal;
         end

         // Counts completed output handshakes, including one that lands in a flush cycle.
         if (out_valid && out_ready) decode_count <= decode_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a sign-extending and a zero-extending
// instance see the same stimulus; a monitor compares every output handshake.
module tb_decode_stage;

   typedef struct {
      int          idx;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [15:0] opc;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm_s, imm_z;
      logic        ill;
   } vec_t;

   logic        clk, rst_n, in_valid, flush, out_ready;
   logic [31:0] INST, pc_in;
   logic        in_ready, out_valid, illegal;
   logic [15:0] opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm, pc_out, decode_count;
   logic        z_in_ready, z_out_valid, z_illegal;
   logic [15:0] z_opcode;
   logic [4:0]  z_rd, z_rs1, z_rs2;
   logic [31:0] z_imm, z_pc_out, z_decode_count;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_hs     = 0;
   vec_t vt[14];
   vec_t sb[$];

   decode_stage #(.XLEN(32), .SIGN_EXT_IMM(1'b1), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .INST(INST), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
      .imm(imm), .pc_out(pc_out), .illegal(illegal), .decode_count(decode_count)
   );

   decode_stage #(.XLEN(32), .SIGN_EXT_IMM(1'b0), .CNT_W(32)) dut_z (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready),
      .INST(INST), .pc_in(pc_in), .flush(flush), .out_valid(z_out_valid),
      .out_ready(out_ready), .opcode(z_opcode), .rd(z_rd), .rs1(z_rs1), .rs2(z_rs2),
      .imm(z_imm), .pc_out(z_pc_out), .illegal(z_illegal), .decode_count(z_decode_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(int idx, logic [31:0] inst, logic [15:0] opc, logic [4:0] rd_e,
                               logic [4:0] rs1_e, logic [4:0] rs2_e, logic [31:0] imm_s,
                               logic [31:0] imm_z, logic ill);
      vec_t v;
      v.idx = idx; v.inst = inst; v.pc = 32'h1000 + 32'(idx * 4);
      v.opc = opc; v.rd = rd_e; v.rs1 = rs1_e; v.rs2 = rs2_e;
      v.imm_s = imm_s; v.imm_z = imm_z; v.ill = ill;
      return v;
   endfunction

   // Monitor: every output handshake must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      vec_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_output", 64'(out_valid), 64'(1'b0));
         end else begin
            e = sb.pop_front();
            n_hs++;
            check($sformatf("v%0d_opcode", e.idx), 64'(opcode), 64'(e.opc));
            check($sformatf("v%0d_rd", e.idx), 64'(rd), 64'(e.rd));
            check($sformatf("v%0d_rs1", e.idx), 64'(rs1), 64'(e.rs1));
            check($sformatf("v%0d_rs2", e.idx), 64'(rs2), 64'(e.rs2));
            check($sformatf("v%0d_imm", e.idx), 64'(imm), 64'(e.imm_s));
            check($sformatf("v%0d_pc", e.idx), 64'(pc_out), 64'(e.pc));
            check($sformatf("v%0d_illegal", e.idx), 64'(illegal), 64'(e.ill));
            check($sformatf("v%0d_zvalid", e.idx), 64'(z_out_valid), 64'(1'b1));
            check($sformatf("v%0d_zimm", e.idx), 64'(z_imm), 64'(e.imm_z));
            check($sformatf("v%0d_zillegal", e.idx), 64'(z_illegal), 64'(e.ill));
         end
      end
   end

   task automatic issue(input int idx, output int waits);
      vec_t e;
      e = vt[idx];
      in_valid = 1'b1;
      INST     = e.inst;
      pc_in    = e.pc;
      waits    = 0;
      @(negedge clk);
      while (!in_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) check($sformatf("v%0d_issue_timeout", idx), 64'(in_ready), 64'(1'b1));
      else           sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic stream(input int idx);
      int w;
      issue(idx, w);
      check($sformatf("v%0d_issue_stall", idx), 64'(w), 64'(0));
   endtask

   initial begin
      int w;
      //             idx inst           opcode   rd rs1 rs2 imm_s          imm_z          ill
      vt[0]  = mk(0,  32'h00000013, 16'h0013, 0, 0,  0, 32'h0,         32'h0,         0);
      vt[1]  = mk(1,  32'hFFF00093, 16'h0013, 1, 0,  0, 32'hFFFFFFFF,  32'h00000FFF,  0);
      vt[2]  = mk(2,  32'h40A5D513, 16'h8293, 10, 11, 0, 32'h0000040A, 32'h0000040A,  0);
      vt[3]  = mk(3,  32'h80A5D513, 16'h0293, 10, 11, 0, 32'hFFFFF80A, 32'h0000080A,  1);
      vt[4]  = mk(4,  32'h002081B3, 16'h0033, 3, 1,  2, 32'h0,         32'h0,         0);
      vt[5]  = mk(5,  32'h407302B3, 16'h8033, 5, 6,  7, 32'h0,         32'h0,         0);
      vt[6]  = mk(6,  32'hFE20AE23, 16'h0123, 0, 1,  2, 32'hFFFFFFFC,  32'h00000FFC,  0);
      vt[7]  = mk(7,  32'h0020A463, 16'h0163, 0, 1,  2, 32'h00000008,  32'h00000008,  1);
      vt[8]  = mk(8,  32'h0000007F, 16'h0000, 0, 0,  0, 32'h0,         32'h0,         1);
      vt[9]  = mk(9,  32'h800000EF, 16'h006F, 1, 0,  0, 32'hFFF00000,  32'h00100000,  0);
      vt[10] = mk(10, 32'h800002B7, 16'h0037, 5, 0,  0, 32'h80000000,  32'h80000000,  0);
      vt[11] = mk(11, 32'h0081A203, 16'h0103, 4, 3,  0, 32'h00000008,  32'h00000008,  0);
      vt[12] = mk(12, 32'h00009067, 16'h0067, 0, 1,  0, 32'h0,         32'h0,         1);
      vt[13] = mk(13, 32'h00000010, 16'h0000, 0, 0,  0, 32'h0,         32'h0,         1);

      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      INST = '0; pc_in = '0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_count", 64'(decode_count), 64'(0));
      check("rst_imm", 64'(imm), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-throughput stream.
      out_ready = 1'b1;
      stream(1); stream(2); stream(4); stream(6);
      @(posedge clk); #1;
      check("stream_count", 64'(decode_count), 64'(4));
      check("stream_drained", 64'(out_valid), 64'(0));

      // Backpressure: v5 held while v9 waits at the input.
      out_ready = 1'b0;
      stream(5);
      in_valid = 1'b1; INST = vt[9].inst; pc_in = vt[9].pc;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("hold_in_ready", 64'(in_ready), 64'(0));
         check("hold_valid", 64'(out_valid), 64'(1));
         check("hold_rd", 64'(rd), 64'(5));
         check("hold_opcode", 64'(opcode), 64'(16'h8033));
         check("hold_pc", 64'(pc_out), 64'(32'h1014));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      issue(9, w);
      @(posedge clk); #1;
      check("bp_count", 64'(decode_count), 64'(6));

      stream(7); stream(10); stream(11); stream(12); stream(13);
      @(posedge clk); #1;
      check("stream2_count", 64'(decode_count), 64'(11));

      // Flush while holding v3 and presenting v8: neither may emerge.
      out_ready = 1'b0;
      stream(3);
      in_valid = 1'b1; INST = vt[8].inst; pc_in = vt[8].pc; flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      void'(sb.pop_back());
      check("flush_valid", 64'(out_valid), 64'(0));
      check("flush_count", 64'(decode_count), 64'(11));
      check("flush_in_ready", 64'(in_ready), 64'(1));
      repeat (2) @(posedge clk);
      #1;
      check("flush_no_capture", 64'(out_valid), 64'(0));

      out_ready = 1'b1;
      stream(8); stream(3);
      @(posedge clk); #1;
      check("final_count", 64'(decode_count), 64'(13));
      check("z_final_count", 64'(z_decode_count), 64'(13));
      check("sb_empty", 64'(sb.size()), 64'(0));
      check("handshakes", 64'(n_hs), 64'(13));

      // Asynchronous reset mid-stream, away from any clock edge.
      out_ready = 1'b0;
      stream(1);
      #2;
      check("pre_rst_valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("arst_valid", 64'(out_valid), 64'(0));
      check("arst_count", 64'(decode_count), 64'(0));
      check("arst_opcode", 64'(opcode), 64'(0));
      check("arst_regs", 64'({rd, rs1, rs2}), 64'(0));
      check("arst_imm", 64'(imm), 64'(0));
      check("arst_pc", 64'(pc_out), 64'(0));
      check("arst_illegal", 64'(illegal), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_valid", 64'(out_valid), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
